dtmr_ctrl: RTL and testbench



---
 rtl/dtmr_ctrl_if.sv | 16 +
 rtl/dtmr_ctrl.sv | 154 +++++++++++++++
 tb/tb_dtmr_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dtmr_ctrl_if.sv
// Voter-side signal bundle for the dynamic-TMR mode controller.
// slave = controller side, master = voter / system side.
interface dtmr_ctrl_if;
  logic        tmr_req;
  logic [2:0]  fault;
  logic        state;
  logic [2:0]  copy_rst;
  logic        recovering;
  logic        err;
  logic [23:0] rec_cnt;

  modport slave  (input  tmr_req, fault,
                  output state, copy_rst, recovering, err, rec_cnt);
  modport master (output tmr_req, fault,
                  input  state, copy_rst, recovering, err, rec_cnt);
endinterface

// File: rtl/dtmr_ctrl.sv
// Mode controller for the dynamic-TMR voter: self-check/request voting, fault filtering,
// per-copy scrub sequencing and sticky error. Define DTMR_STATS_EN for per-copy recovery counters.
module dtmr_ctrl #(
  parameter int unsigned CHECK_PERIOD = 1024,
  parameter int unsigned CHECK_LEN    = 64,
  parameter int unsigned FAULT_THRESH = 3,
  parameter int unsigned RECOVER_CYC  = 8
) (
  input  logic         clk,
  input  logic         rst,
  dtmr_ctrl_if.slave   bus
);

  localparam int unsigned NCOPY = 3;
  localparam int unsigned PW    = (CHECK_PERIOD > 1) ? $clog2(CHECK_PERIOD) : 1;
  localparam int unsigned WW    = (CHECK_LEN > 1)    ? $clog2(CHECK_LEN)    : 1;
  localparam int unsigned RW    = (RECOVER_CYC > 1)  ? $clog2(RECOVER_CYC)  : 1;
  localparam int unsigned FW    = $clog2(FAULT_THRESH + 1);
  localparam int unsigned IW    = 2;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RECOVER, S_ERROR} st_t;

  st_t              st;
  logic [PW-1:0]    period_cnt;
  logic [WW-1:0]    win_cnt;
  logic [RW-1:0]    rec_tmr;
  logic [FW-1:0]    cnt     [NCOPY];
  logic [FW-1:0]    cnt_inc [NCOPY];
  logic [NCOPY-1:0] fail;
  logic [IW-1:0]    fail_idx;
  logic [1:0]       n_fail;
  logic             any_cnt;
  logic             state_q;
  logic             recovering_q;
  logic             err_q;
  logic [NCOPY-1:0] copy_rst_q;

  // Next value of each consecutive-fault counter; failure is judged on this value.
  always_comb begin
    fail     = '0;
    fail_idx = '0;
    n_fail   = '0;
    any_cnt  = 1'b0;
    for (int i = 0; i < NCOPY; i++) begin
      cnt_inc[i] = '0;
      if (bus.fault[i])
        cnt_inc[i] = (cnt[i] >= FW'(FAULT_THRESH)) ? FW'(FAULT_THRESH) : cnt[i] + FW'(1);
      fail[i] = (cnt_inc[i] == FW'(FAULT_THRESH));
      if (fail[i]) begin
        n_fail   = n_fail + 2'd1;
        fail_idx = IW'(i);
      end
      if (cnt_inc[i] != '0) any_cnt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= S_IDLE;
      period_cnt   <= '0;
      win_cnt      <= '0;
      rec_tmr      <= '0;
      state_q      <= 1'b0;
      recovering_q <= 1'b0;
      err_q        <= 1'b0;
      copy_rst_q   <= '0;
      for (int i = 0; i < NCOPY; i++) cnt[i] <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (bus.tmr_req || (period_cnt == PW'(CHECK_PERIOD - 1))) begin
            st         <= S_ACTIVE;
            period_cnt <= '0;
            win_cnt    <= WW'(CHECK_LEN - 1);
            state_q    <= 1'b1;
            for (int i = 0; i < NCOPY; i++) cnt[i] <= '0;
          end else begin
            period_cnt <= period_cnt + PW'(1);
          end
        end

        S_ACTIVE: begin
          for (int i = 0; i < NCOPY; i++) cnt[i] <= cnt_inc[i];
          if (n_fail >= 2'd2) begin
            st    <= S_ERROR;
            err_q <= 1'b1;
          end else if (n_fail == 2'd1) begin
            st           <= S_RECOVER;
            recovering_q <= 1'b1;
            copy_rst_q   <= NCOPY'(1) << fail_idx;
            rec_tmr      <= RW'(RECOVER_CYC - 1);
            for (int i = 0; i < NCOPY; i++) cnt[i] <= '0;
          end else if (win_cnt == '0) begin
            // Leave voting only once the request is gone and no copy is suspect.
            if (!bus.tmr_req && !any_cnt) begin
              st      <= S_IDLE;
              state_q <= 1'b0;
            end else begin
              win_cnt <= WW'(CHECK_LEN - 1);
            end
          end else begin
            win_cnt <= win_cnt - WW'(1);
          end
        end

        S_RECOVER: begin
          for (int i = 0; i < NCOPY; i++) cnt[i] <= '0;
          if (rec_tmr == '0) begin
            st           <= S_ACTIVE;
            recovering_q <= 1'b0;
            copy_rst_q   <= '0;
            win_cnt      <= WW'(CHECK_LEN - 1);
          end else begin
            rec_tmr <= rec_tmr - RW'(1);
          end
        end

        default: begin
          st           <= S_ERROR;
          state_q      <= 1'b1;
          err_q        <= 1'b1;
          recovering_q <= 1'b0;
          copy_rst_q   <= '0;
        end
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.copy_rst   = copy_rst_q;
  assign bus.recovering = recovering_q;
  assign bus.err        = err_q;

`ifdef DTMR_STATS_EN
  logic [7:0] rec_q [NCOPY];
  logic       rec_enter;

  assign rec_enter = (st == S_ACTIVE) && (n_fail == 2'd1);

  // Saturating per-copy recovery counters, bumped on entry to RECOVER.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCOPY; i++) rec_q[i] <= '0;
    end else if (rec_enter && (rec_q[fail_idx] != 8'hFF)) begin
      rec_q[fail_idx] <= rec_q[fail_idx] + 8'd1;
    end
  end

  assign bus.rec_cnt = {rec_q[2], rec_q[1], rec_q[0]};
`else
  assign bus.rec_cnt = '0;
`endif

endmodule

// File: tb/tb_dtmr_ctrl.sv
// Self-checking bench for dtmr_ctrl with CHECK_PERIOD=16, CHECK_LEN=8, FAULT_THRESH=3, RECOVER_CYC=4.
module tb_dtmr_ctrl;

`ifdef DTMR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtmr_ctrl_if bus();

  dtmr_ctrl #(
    .CHECK_PERIOD(16),
    .CHECK_LEN   (8),
    .FAULT_THRESH(3),
    .RECOVER_CYC (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          ph;
    logic        rst;
    logic        req;
    logic [2:0]  fault;
    logic        st;
    logic [2:0]  cr;
    logic        rec;
    logic        err;
    logic [23:0] rc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic string ph_name(input int p);
    case (p)
      0: return "reset";
      1: return "selfcheck";
      2: return "request";
      3: return "transient";
      4: return "recovery";
      5: return "error";
      6: return "rst_mid_recover";
      default: return "unknown";
    endcase
  endfunction

  function automatic vec_t mk(input int ph, input logic r, input logic q, input logic [2:0] f,
                              input logic s, input logic [2:0] cr, input logic rec,
                              input logic e, input logic [23:0] rc);
    vec_t v;
    v.ph = ph; v.rst = r; v.req = q; v.fault = f;
    v.st = s; v.cr = cr; v.rec = rec; v.err = e;
    v.rc = STATS ? rc : 24'h0;
    return v;
  endfunction

  function automatic void add(input int n, input int ph, input logic r, input logic q,
                              input logic [2:0] f, input logic s, input logic [2:0] cr,
                              input logic rec, input logic e, input logic [23:0] rc);
    for (int i = 0; i < n; i++) tbl.push_back(mk(ph, r, q, f, s, cr, rec, e, rc));
  endfunction

  task automatic drive(input vec_t v);
    rst         = v.rst;
    bus.tmr_req = v.req;
    bus.fault   = v.fault;
    sb.push_back(v);
  endtask

  task automatic check_out();
    vec_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    if (bus.state !== e.st || bus.copy_rst !== e.cr || bus.recovering !== e.rec ||
        bus.err !== e.err || bus.rec_cnt !== e.rc) begin
      bad++;
      $display("FAIL %s @%0t: got state=%b copy_rst=%b recovering=%b err=%b rec_cnt=%h, want state=%b copy_rst=%b recovering=%b err=%b rec_cnt=%h",
               ph_name(e.ph), $time, bus.state, bus.copy_rst, bus.recovering, bus.err, bus.rec_cnt,
               e.st, e.cr, e.rec, e.err, e.rc);
    end
  endtask

  task automatic run(input int n, input int ph, input logic r, input logic q,
                     input logic [2:0] f, input logic s, input logic [2:0] cr,
                     input logic rec, input logic e, input logic [23:0] rc);
    for (int i = 0; i < n; i++) begin
      drive(mk(ph, r, q, f, s, cr, rec, e, rc));
      @(posedge clk);
      #1;
      check_out();
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.tmr_req = 1'b0;
    bus.fault   = 3'b000;

    //   n  ph rst req fault   st cr      rec err rc
    add( 2, 0, 1,  0,  3'b000, 0, 3'b000, 0,  0,  24'h0);
    // automatic check: 15 idle cycles, rises on the 16th, 8 voting cycles
    add(15, 1, 0,  0,  3'b000, 0, 3'b000, 0,  0,  24'h0);
    add( 8, 1, 0,  0,  3'b000, 1, 3'b000, 0,  0,  24'h0);
    add( 1, 1, 0,  0,  3'b000, 0, 3'b000, 0,  0,  24'h0);
    // request held 20 cycles, then state stays until the next window expiry
    add(20, 2, 0,  1,  3'b000, 1, 3'b000, 0,  0,  24'h0);
    add( 4, 2, 0,  0,  3'b000, 1, 3'b000, 0,  0,  24'h0);
    add( 1, 2, 0,  0,  3'b000, 0, 3'b000, 0,  0,  24'h0);
    // transient faults never reach the threshold
    add( 1, 3, 0,  1,  3'b000, 1, 3'b000, 0,  0,  24'h0);
    add( 2, 3, 0,  0,  3'b001, 1, 3'b000, 0,  0,  24'h0);
    add( 1, 3, 0,  0,  3'b000, 1, 3'b000, 0,  0,  24'h0);
    add( 2, 3, 0,  0,  3'b001, 1, 3'b000, 0,  0,  24'h0);
    add( 2, 3, 0,  0,  3'b000, 1, 3'b000, 0,  0,  24'h0);
    add( 1, 3, 0,  0,  3'b000, 0, 3'b000, 0,  0,  24'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check_out();
    end

    // recovery of copy 2; faults during scrub are ignored
    run( 1, 4, 0, 1, 3'b000, 1, 3'b000, 0, 0, 24'h0);
    run( 2, 4, 0, 0, 3'b010, 1, 3'b000, 0, 0, 24'h0);
    run( 1, 4, 0, 0, 3'b010, 1, 3'b010, 1, 0, 24'h000100);
    run( 3, 4, 0, 0, 3'b111, 1, 3'b010, 1, 0, 24'h000100);
    run( 1, 4, 0, 0, 3'b111, 1, 3'b000, 0, 0, 24'h000100);
    run( 7, 4, 0, 0, 3'b000, 1, 3'b000, 0, 0, 24'h000100);
    run( 1, 4, 0, 0, 3'b000, 0, 3'b000, 0, 0, 24'h000100);

    // simultaneous failure of two copies is sticky until rst
    run( 1, 5, 0, 1, 3'b000, 1, 3'b000, 0, 0, 24'h000100);
    run( 2, 5, 0, 0, 3'b011, 1, 3'b000, 0, 0, 24'h000100);
    run( 1, 5, 0, 0, 3'b011, 1, 3'b000, 0, 1, 24'h000100);
    run(50, 5, 0, 0, 3'b101, 1, 3'b000, 0, 1, 24'h000100);
    run( 1, 5, 1, 0, 3'b000, 0, 3'b000, 0, 0, 24'h0);

    // rst during the second scrub cycle, then the period restarts from zero
    run( 1, 6, 0, 1, 3'b000, 1, 3'b000, 0, 0, 24'h0);
    run( 2, 6, 0, 0, 3'b100, 1, 3'b000, 0, 0, 24'h0);
    run( 1, 6, 0, 0, 3'b100, 1, 3'b100, 1, 0, 24'h010000);
    run( 1, 6, 0, 0, 3'b000, 1, 3'b100, 1, 0, 24'h010000);
    run( 1, 6, 1, 0, 3'b000, 0, 3'b000, 0, 0, 24'h0);
    run(15, 6, 0, 0, 3'b000, 0, 3'b000, 0, 0, 24'h0);
    run( 1, 6, 0, 0, 3'b000, 1, 3'b000, 0, 0, 24'h0);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
